// File: rtl/flash_cmd_seq_if.sv
// Host-side command handshake of the flash command sequencer.
// The host (master) issues start/cmd/addr/wdata; the sequencer (slave) reports busy/done/error/rdata.
interface flash_cmd_seq_if;
    logic        start;
    logic [1:0]  cmd;
    logic [18:0] addr;
    logic [7:0]  wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  rdata;

    modport master (output start, cmd, addr, wdata, input busy, done, error, rdata);
    modport slave  (input start, cmd, addr, wdata, output busy, done, error, rdata);
endinterface

// File: rtl/flash_cmd_seq.sv
// Flash command sequencer: expands one host command into the JEDEC unlock/command
// write sequence on the byte-level ROM controller, then runs DQ7/DQ5 data polling.
module flash_cmd_seq #(
    parameter int          WR_GAP   = 8,
    parameter int          RD_WAIT  = 9,
    parameter logic [23:0] POLL_MAX = 24'hFFFFFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    flash_cmd_seq_if.slave        host,
    output logic                  rom_wr_addr,
    output logic                  rom_wr_data,
    output logic                  rom_rd_data,
    output logic [7:0]            rom_wr_buffer,
    input  logic [7:0]            rom_rd_buffer
);

    typedef enum logic [1:0] {
        CMD_READ   = 2'b00,
        CMD_PROG   = 2'b01,
        CMD_SERASE = 2'b10,
        CMD_CERASE = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADR0,
        S_ADR1,
        S_ADR2,
        S_ACC,
        S_WAIT,
        S_POLL_EVAL,
        S_FIN
    } state_e;

    // Wait counters count down to zero, so they are loaded with the gap minus one.
    localparam logic [7:0] WR_GAP_M1  = 8'(WR_GAP - 1);
    localparam logic [7:0] RD_WAIT_M1 = 8'(RD_WAIT - 1);

    state_e      state_q, state_d;
    cmd_e        cmd_q, cmd_d;
    logic [18:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [2:0]  step_q, step_d;
    logic [7:0]  wait_q, wait_d;
    logic [23:0] poll_cnt_q, poll_cnt_d;
    logic        polling_q, polling_d;
    logic        confirm_q, confirm_d;
    logic        error_q, error_d;
    logic [7:0]  rdata_q, rdata_d;

    // Current access unit, derived from the command script position.
    logic        acc_read;
    logic [18:0] acc_addr;
    logic [7:0]  acc_data;
    logic [2:0]  last_step;
    logic        exp_dq7;

    // Script table: which address/data the current step writes, or which address is read.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
        acc_read  = 1'b0;
        acc_addr  = addr_q;
        acc_data  = wdata_q;
        last_step = (cmd_q == CMD_PROG) ? 3'd3 : 3'd5;
        exp_dq7   = (cmd_q == CMD_PROG) ? wdata_q[7] : 1'b1;
        if (cmd_q == CMD_READ || polling_q) begin
            acc_read = 1'b1;
            acc_addr = (cmd_q == CMD_CERASE) ? 19'h00000 : addr_q;
        end else begin
            case (step_q)
                3'd0: begin acc_addr = 19'h00555; acc_data = 8'hAA; end
                3'd1: begin acc_addr = 19'h002AA; acc_data = 8'h55; end
                3'd2: begin
                    acc_addr = 19'h00555;
                    acc_data = (cmd_q == CMD_PROG) ? 8'hA0 : 8'h80;
                end
                3'd3: begin
                    if (cmd_q == CMD_PROG) begin
                        acc_addr = addr_q;
                        acc_data = wdata_q;
                    end else begin
                        acc_addr = 19'h00555;
                        acc_data = 8'hAA;
                    end
                end
                3'd4: begin acc_addr = 19'h002AA; acc_data = 8'h55; end
                default: begin
                    if (cmd_q == CMD_CERASE) begin
                        acc_addr = 19'h00555;
                        acc_data = 8'h10;
                    end else begin
                        acc_addr = addr_q;
                        acc_data = 8'h30;
                    end
                end
            endcase
        end
    end

    // ROM strobes and write buffer decoded from the state; all zero outside an access.
    always_comb begin
        rom_wr_addr   = 1'b0;
        rom_wr_data   = 1'b0;
        rom_rd_data   = 1'b0;
        rom_wr_buffer = 8'h00;
        case (state_q)
            S_ADR0: begin rom_wr_addr = 1'b1; rom_wr_buffer = acc_addr[7:0]; end
            S_ADR1: begin rom_wr_addr = 1'b1; rom_wr_buffer = acc_addr[15:8]; end
            S_ADR2: begin rom_wr_addr = 1'b1; rom_wr_buffer = {5'b00000, acc_addr[18:16]}; end
            S_ACC: begin
                rom_wr_data   = ~acc_read;
                rom_rd_data   = acc_read;
                rom_wr_buffer = acc_read ? 8'h00 : acc_data;
            end
            default: ;
        endcase
    end

    // Next-state logic: script stepping, wait gaps and the DQ7/DQ5 poll decision.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        step_d     = step_q;
        wait_d     = wait_q;
        poll_cnt_d = poll_cnt_q;
        polling_d  = polling_q;
        confirm_d  = confirm_q;
        error_d    = error_q;
        rdata_d    = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (host.start) begin
                    state_d    = S_ADR0;
                    cmd_d      = cmd_e'(host.cmd);
                    addr_d     = host.addr;
                    wdata_d    = host.wdata;
                    step_d     = 3'd0;
                    polling_d  = 1'b0;
                    confirm_d  = 1'b0;
                    poll_cnt_d = 24'd0;
                    error_d    = 1'b0;
                end
            end
            S_ADR0: state_d = S_ADR1;
            S_ADR1: state_d = S_ADR2;
            S_ADR2: state_d = S_ACC;
            S_ACC: begin
                state_d = S_WAIT;
                wait_d  = acc_read ? RD_WAIT_M1 : WR_GAP_M1;
            end
            S_WAIT: begin
                if (wait_q != 8'd0) begin
                    wait_d = wait_q - 8'd1;
                end else if (acc_read) begin
                    // Last wait cycle of a read: the ROM controller's byte is valid now.
                    rdata_d = rom_rd_buffer;
                    if (polling_q) begin
                        poll_cnt_d = poll_cnt_q + 24'd1;
                        state_d    = S_POLL_EVAL;
                    end else begin
                        state_d = S_FIN;
                    end
                end else if (step_q == last_step) begin
                    polling_d = 1'b1;
                    state_d   = S_ADR0;
                end else begin
                    step_d  = step_q + 3'd1;
                    state_d = S_ADR0;
                end
            end
            S_POLL_EVAL: begin
                if (rdata_q[7] == exp_dq7) begin
                    error_d = 1'b0;
                    state_d = S_FIN;
                end else if (confirm_q) begin
                    // DQ7 still wrong after DQ5 went high: the device reports a failure.
                    error_d = 1'b1;
                    state_d = S_FIN;
                end else if (rdata_q[5]) begin
                    // DQ5 may rise just as the operation completes, so read once more.
                    confirm_d = 1'b1;
                    state_d   = S_ADR0;
                end else if (poll_cnt_q == POLL_MAX) begin
                    error_d = 1'b1;
                    state_d = S_FIN;
                end else begin
                    state_d = S_ADR0;
                end
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cmd_q      <= CMD_READ;
            addr_q     <= '0;
            wdata_q    <= '0;
            step_q     <= '0;
            wait_q     <= '0;
            poll_cnt_q <= '0;
            polling_q  <= 1'b0;
            confirm_q  <= 1'b0;
            error_q    <= 1'b0;
            rdata_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            step_q     <= step_d;
            wait_q     <= wait_d;
            poll_cnt_q <= poll_cnt_d;
            polling_q  <= polling_d;
            confirm_q  <= confirm_d;
            error_q    <= error_d;
            rdata_q    <= rdata_d;
        end
    end

    assign host.busy  = (state_q != S_IDLE) && (state_q != S_FIN);
    assign host.done  = (state_q == S_FIN);
    assign host.error = error_q;
    assign host.rdata = rdata_q;

endmodule

// File: tb/tb_flash_cmd_seq.sv
// Self-checking bench for flash_cmd_seq: table vectors, hand-written corner sequences
// and random commands checked against a transaction-level reference model.
module tb_flash_cmd_seq;

    localparam int WR_GAP   = 8;
    localparam int RD_WAIT  = 9;
    localparam int POLL_MAX = 4;

    typedef struct packed {
        logic        is_rd;
        logic [18:0] a;
        logic [7:0]  d;
    } acc_t;

    typedef struct {
        logic [1:0]       cmd;
        logic [18:0]      addr;
        logic [7:0]       wdata;
        logic [3:0][7:0]  resp;
        logic [7:0]       dflt;
        logic             exp_err;
        logic [7:0]       exp_rdata;
        int               exp_nacc;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rom_wr_addr, rom_wr_data, rom_rd_data;
    logic [7:0] rom_wr_buffer;
    logic [7:0] rom_rd_buffer;

    flash_cmd_seq_if hif ();

    flash_cmd_seq #(
        .WR_GAP   (WR_GAP),
        .RD_WAIT  (RD_WAIT),
        .POLL_MAX (24'(POLL_MAX))
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .host          (hif),
        .rom_wr_addr   (rom_wr_addr),
        .rom_wr_data   (rom_wr_data),
        .rom_rd_data   (rom_rd_data),
        .rom_wr_buffer (rom_wr_buffer),
        .rom_rd_buffer (rom_rd_buffer)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_errors = 0;
    int         g_cyc;
    acc_t       mon_q[$];
    int         mon_cyc[$];
    int         ab_cyc[$];
    logic [7:0] ab_val[$];
    logic [7:0] resp_list[$];
    logic [7:0] resp_dflt;
    int         rd_idx, rd_due;
    logic [7:0] rd_pend;
    int         proto_bad, a_cnt, last_wr_cyc;
    logic [18:0] a_asm;
    int         busy_low, done_cyc;
    logic       done_err;
    logic [7:0] done_rdata;
    acc_t       exp_q[$];
    logic       exp_err;
    logic [7:0] exp_rdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] resp_at(input int n);
        return (n < resp_list.size()) ? resp_list[n] : resp_dflt;
    endfunction

    // One clock: sample at the falling edge, log strobes, then drive the ROM read byte.
    // The read byte is only correct on the last wait cycle, inverted otherwise.
    task automatic cycle();
        int   n_str;
        acc_t t;
        @(negedge clk);
        g_cyc++;
        n_str = int'(rom_wr_addr) + int'(rom_wr_data) + int'(rom_rd_data);
        if (n_str > 1) proto_bad++;
        if (n_str != 0 && last_wr_cyc >= 0) begin
            if (g_cyc != last_wr_cyc + WR_GAP + 1) proto_bad++;
            last_wr_cyc = -1;
        end
        if (rom_wr_addr) begin
            case (a_cnt)
                0: a_asm[7:0] = rom_wr_buffer;
                1: a_asm[15:8] = rom_wr_buffer;
                2: begin
                    a_asm[18:16] = rom_wr_buffer[2:0];
                    if (rom_wr_buffer[7:3] != 5'd0) proto_bad++;
                end
                default: proto_bad++;
            endcase
            a_cnt++;
            ab_cyc.push_back(g_cyc);
            ab_val.push_back(rom_wr_buffer);
        end
        if (rom_wr_data || rom_rd_data) begin
            if (a_cnt != 3) proto_bad++;
            a_cnt   = 0;
            t.is_rd = rom_rd_data;
            t.a     = a_asm;
            t.d     = rom_rd_data ? 8'h00 : rom_wr_buffer;
            mon_q.push_back(t);
            mon_cyc.push_back(g_cyc);
            if (rom_wr_data) last_wr_cyc = g_cyc;
            if (rom_rd_data) begin
                rd_pend = resp_at(rd_idx);
                rd_idx++;
                rd_due = g_cyc + RD_WAIT;
            end
        end
        rom_rd_buffer = (g_cyc == rd_due) ? rd_pend : ~rd_pend;
    endtask

    task automatic start_cmd(input logic [1:0] c, input logic [18:0] a, input logic [7:0] d);
        mon_q.delete();
        mon_cyc.delete();
        ab_cyc.delete();
        ab_val.delete();
        rd_idx = 0; rd_due = -100; a_cnt = 0; last_wr_cyc = -1; proto_bad = 0;
        hif.start = 1'b1; hif.cmd = c; hif.addr = a; hif.wdata = d;
        g_cyc = 0;
        cycle();
        hif.start = 1'b0;
        hif.cmd   = 2'($urandom);
        hif.addr  = 19'($urandom);
        hif.wdata = 8'($urandom);
    endtask

    // Run until done (bounded), optionally poking start while busy and in the done cycle.
    task automatic wait_done(input string tag, input logic poke);
        int n_acc;
        busy_low = 0;
        done_cyc = -1;
        for (int i = 0; i < 3000; i++) begin
            if (hif.done) begin
                done_cyc   = g_cyc;
                done_err   = hif.error;
                done_rdata = hif.rdata;
                break;
            end
            if (!hif.busy) busy_low++;
            if (poke) begin
                hif.start = ($urandom_range(0, 2) == 0);
                hif.cmd   = 2'($urandom);
            end
            cycle();
        end
        check({tag, "_done_seen"}, 32'(done_cyc > 0), 32'd1);
        check({tag, "_busy_held"}, busy_low, 0);
        hif.start = poke;
        cycle();
        hif.start = 1'b0;
        check({tag, "_done_pulse"}, {hif.done, hif.busy}, 0);
        n_acc = mon_q.size();
        repeat (4) cycle();
        check({tag, "_idle_quiet"}, mon_q.size(), n_acc);
    endtask

    function automatic acc_t w(input logic [18:0] a, input logic [7:0] d);
        acc_t t;
        t.is_rd = 1'b0; t.a = a; t.d = d;
        return t;
    endfunction

    function automatic acc_t r(input logic [18:0] a);
        acc_t t;
        t.is_rd = 1'b1; t.a = a; t.d = 8'h00;
        return t;
    endfunction

    // Reference: list of accesses and final status, from the command scripts and poll rules.
    task automatic model(input logic [1:0] c, input logic [18:0] a, input logic [7:0] d);
        logic [18:0] pa;
        logic        dq7, confirm;
        logic [7:0]  b;
        int          n;
        exp_q.delete();
        exp_err = 1'b0;
        if (c == 2'b00) begin
            exp_q.push_back(r(a));
            exp_rdata = resp_at(0);
            return;
        end
        exp_q.push_back(w(19'h555, 8'hAA));
        exp_q.push_back(w(19'h2AA, 8'h55));
        if (c == 2'b01) begin
            exp_q.push_back(w(19'h555, 8'hA0));
            exp_q.push_back(w(a, d));
        end else begin
            exp_q.push_back(w(19'h555, 8'h80));
            exp_q.push_back(w(19'h555, 8'hAA));
            exp_q.push_back(w(19'h2AA, 8'h55));
            exp_q.push_back((c == 2'b10) ? w(a, 8'h30) : w(19'h555, 8'h10));
        end
        pa      = (c == 2'b11) ? 19'h0 : a;
        dq7     = (c == 2'b01) ? d[7] : 1'b1;
        confirm = 1'b0;
        n       = 0;
        for (int k = 0; k < 100; k++) begin
            b = resp_at(n);
            n++;
            exp_q.push_back(r(pa));
            exp_rdata = b;
            if (b[7] == dq7) begin exp_err = 1'b0; break; end
            if (confirm) begin exp_err = 1'b1; break; end
            if (b[5]) confirm = 1'b1;
            else if (n >= POLL_MAX) begin exp_err = 1'b1; break; end
        end
    endtask

    task automatic compare_model(input string tag);
        int n_bad = 0;
        check({tag, "_nacc_model"}, mon_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            if (mon_q[i] !== exp_q[i]) begin
                if (n_bad == 0)
                    $display("access %0d differs: got rd=%0b a=%05h d=%02h, expected rd=%0b a=%05h d=%02h", i,
                             mon_q[i].is_rd, mon_q[i].a, mon_q[i].d, exp_q[i].is_rd, exp_q[i].a, exp_q[i].d);
                n_bad++;
            end
        end
        check({tag, "_accesses"}, n_bad, 0);
        check({tag, "_error"}, done_err, exp_err);
        check({tag, "_rdata"}, done_rdata, exp_rdata);
        check({tag, "_protocol"}, proto_bad, 0);
    endtask

    task automatic run_vec(input string tag, input logic [1:0] c, input logic [18:0] a, input logic [7:0] d,
                           input logic poke);
        start_cmd(c, a, d);
        wait_done(tag, poke);
        model(c, a, d);
        compare_model(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        check(tag, {hif.busy, hif.done, hif.error, hif.rdata, rom_wr_addr, rom_wr_data, rom_rd_data, rom_wr_buffer}, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vecs[9];
        logic [7:0] exp_ab[3];
        int         n_mon;
        int         found;

        vecs[0] = '{2'b01, 19'h12345, 8'h80, 32'h80000000, 8'h80, 1'b0, 8'h80, 8};
        vecs[1] = '{2'b10, 19'h70000, 8'h00, 32'h20202020, 8'h20, 1'b1, 8'h20, 8};
        vecs[2] = '{2'b11, 19'h3FFFF, 8'h00, 32'h80808000, 8'h80, 1'b0, 8'h80, 8};
        vecs[3] = '{2'b01, 19'h00001, 8'h80, 32'h00000000, 8'h00, 1'b1, 8'h00, 8};
        vecs[4] = '{2'b01, 19'h7FFFF, 8'h00, 32'h7F7F7FFF, 8'h7F, 1'b0, 8'h7F, 6};
        vecs[5] = '{2'b00, 19'h7FFFF, 8'h00, 32'hA5A5A5A5, 8'hA5, 1'b0, 8'hA5, 1};
        vecs[6] = '{2'b10, 19'h40000, 8'h00, 32'hA4A4A424, 8'hA4, 1'b0, 8'hA4, 8};
        vecs[7] = '{2'b11, 19'h00000, 8'h00, 32'h08080808, 8'h08, 1'b1, 8'h08, 10};
        vecs[8] = '{2'b01, 19'h2A5A5, 8'h2A, 32'h55555555, 8'h55, 1'b0, 8'h55, 5};

        rst_n = 1'b0;
        hif.start = 1'b0; hif.cmd = 2'b00; hif.addr = '0; hif.wdata = '0;
        rom_rd_buffer = 8'h00; rd_pend = 8'h00; rd_due = -100; g_cyc = 0;
        a_cnt = 0; last_wr_cyc = -1; proto_bad = 0; a_asm = '0;
        resp_dflt = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        // Read with exact cycle timing.
        resp_list = '{8'h7E};
        resp_dflt = 8'h00;
        start_cmd(2'b00, 19'h5A3C1, 8'h00);
        wait_done("read", 1'b0);
        exp_ab = '{8'hC1, 8'hA3, 8'h05};
        check("read_abytes_n", ab_val.size(), 3);
        if (ab_val.size() >= 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("read_abyte%0d_val", i), ab_val[i], exp_ab[i]);
                check($sformatf("read_abyte%0d_cyc", i), ab_cyc[i], i + 1);
            end
        end
        check("read_nacc", mon_cyc.size(), 1);
        if (mon_cyc.size() >= 1) check("read_strobe_cyc", mon_cyc[0], 4);
        check("read_done_cyc", done_cyc, 14);
        model(2'b00, 19'h5A3C1, 8'h00);
        compare_model("read");

        // Table vectors with hand-derived outcomes.
        for (int v = 0; v < 9; v++) begin
            resp_list.delete();
            for (int j = 0; j < 4; j++) resp_list.push_back(vecs[v].resp[j]);
            resp_dflt = vecs[v].dflt;
            run_vec($sformatf("vec%0d", v), vecs[v].cmd, vecs[v].addr, vecs[v].wdata, 1'b0);
            check($sformatf("vec%0d_exp_err", v), done_err, vecs[v].exp_err);
            check($sformatf("vec%0d_exp_rdata", v), done_rdata, vecs[v].exp_rdata);
            check($sformatf("vec%0d_exp_nacc", v), mon_q.size(), vecs[v].exp_nacc);
        end

        // Chip erase with start pulses while busy and in the done cycle.
        resp_list = '{8'h00, 8'h80};
        resp_dflt = 8'h80;
        run_vec("chip_poke", 2'b11, 19'h12345, 8'h00, 1'b1);
        if (mon_q.size() >= 7) begin
            check("chip_last_write", mon_q[5], w(19'h555, 8'h10));
            check("chip_poll_addr", mon_q[6], r(19'h0));
        end else begin
            check("chip_nacc_min", mon_q.size(), 7);
        end

        // Reset during the third unlock write of a program command.
        resp_list.delete();
        resp_dflt = 8'h80;
        start_cmd(2'b01, 19'h0ABCD, 8'h80);
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            if (mon_q.size() == 2 && rom_wr_addr) found = 1;
            else cycle();
        end
        check("abort_reached", found, 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("abort_reset_vals");
        n_mon = mon_q.size() + ab_val.size();
        repeat (3) cycle();
        check("abort_no_strobes", mon_q.size() + ab_val.size(), n_mon);
        check_reset_vals("abort_held");
        rst_n = 1'b1;
        cycle();
        resp_list = '{8'h3C};
        run_vec("post_reset_read", 2'b00, 19'h00F0F, 8'h00, 1'b0);

        // Random commands against the reference model.
        for (int k = 0; k < 30; k++) begin
            resp_list.delete();
            for (int j = 0; j < 4; j++) resp_list.push_back(8'($urandom));
            resp_dflt = 8'($urandom);
            run_vec($sformatf("rnd%0d", k), 2'($urandom_range(0, 3)), 19'($urandom), 8'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
